// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Single-port memory req/gnt/rvalid channel shared by IF and MEM.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : IF/MEM arbiter for the unified memory, LSU priority with bounded
//            fetch starvation; one outstanding transaction at a time.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,

    input  wire logic        if_req_i,
    input  wire logic [31:0] if_addr_i,
    input  wire logic        if_kill_i,
    output logic [31:0]      if_rdata_o,
    output logic             if_valid_o,
    output logic             stall_if_o,

    input  wire logic        lsu_req_i,
    input  wire logic        lsu_we_i,
    input  wire logic [3:0]  lsu_be_i,
    input  wire logic [31:0] lsu_addr_i,
    input  wire logic [31:0] lsu_wdata_i,
    output logic [31:0]      lsu_rdata_o,
    output logic             lsu_valid_o,
    output logic             stall_mem_o,

    mem_port_arbiter_if.master mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [3:0] C_STARVE_LIM = 4'(STARVE_MAX);

    state_e      state_q, state_d;
    logic        owner_if_q, owner_if_d;
    logic        drop_q, drop_d;
    logic [3:0]  starve_q, starve_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic w_if_elig;
    logic w_pick_if;
    logic w_done;

    assign w_if_elig = if_req_i & ~if_kill_i;
    assign w_pick_if = w_if_elig & (~lsu_req_i | (starve_q == C_STARVE_LIM));
    // Gating with reset keeps a completion from leaking out during a reset cycle.
    assign w_done    = (state_q == WAIT) & mem.mem_rvalid_i & ~rst_i;

    assign if_valid_o  = w_done & owner_if_q & ~drop_q & ~if_kill_i;
    assign lsu_valid_o = w_done & ~owner_if_q;
    assign if_rdata_o  = mem.mem_rdata_i;
    assign lsu_rdata_o = mem.mem_rdata_i;
    assign stall_if_o  = if_req_i & ~if_valid_o & ~if_kill_i;
    assign stall_mem_o = lsu_req_i & ~lsu_valid_o;

    assign mem.mem_req_o   = mem_req_q;
    assign mem.mem_we_o    = mem_we_q;
    assign mem.mem_be_o    = mem_be_q;
    assign mem.mem_addr_o  = mem_addr_q;
    assign mem.mem_wdata_o = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        owner_if_d  = owner_if_q;
        drop_d      = drop_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (w_pick_if) begin
                    state_d     = REQ;
                    owner_if_d  = 1'b1;
                    drop_d      = 1'b0;
                    starve_d    = 4'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'hF;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = 32'h0;
                end else if (lsu_req_i) begin
                    state_d     = REQ;
                    owner_if_d  = 1'b0;
                    drop_d      = 1'b0;
                    // A waiting fetch (even one being killed) counts toward starvation.
                    if (if_req_i && (starve_q < C_STARVE_LIM)) begin
                        starve_d = starve_q + 4'd1;
                    end
                    mem_req_d   = 1'b1;
                    mem_we_d    = lsu_we_i;
                    mem_be_d    = lsu_be_i;
                    mem_addr_d  = lsu_addr_i;
                    mem_wdata_d = lsu_wdata_i;
                end
            end
            REQ: begin
                if (owner_if_q && if_kill_i) begin
                    drop_d = 1'b1;
                end
                if (mem.mem_gnt_i) begin
                    state_d   = WAIT;
                    mem_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid_i) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end else if (owner_if_q && if_kill_i) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_if_q  <= 1'b0;
            drop_q      <= 1'b0;
            starve_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_if_q  <= owner_if_d;
            drop_q      <= drop_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule
`default_nettype wire
